bv_lookup_stage: RTL and testbench

- Parametrised bit-vector lookup stage for the multi-stage BV packet-match pipeline.
- One key field indexes a 2^KEY_W x BV_W table and returns a BV_W-bit rule vector each cycle, with a valid aligned to the data.
- A second RAM port serves control-plane set/readback through a ready handshake.
- An automatic zeroing sweep after reset, and same-cycle write forwarding, are added over the fixed 9-bit/36-bit stage.

---
 rtl/bv_lookup_pkg.sv | 23 ++
 rtl/bv_ram_dp.sv | 48 ++++
 rtl/bv_lookup_stage.sv | 194 +++++++++++++++++++
 tb/tb_bv_lookup_stage.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bv_lookup_pkg.sv
// bv_lookup_pkg
// Shared types and constants for the bit-vector lookup stage.
//   state_e      - control-port FSM encoding
//   DEF_*        - default key width, vector width and RAM read latency
//   set_data_w() - width of the packed {addr, vector} set word
package bv_lookup_pkg;

  localparam int DEF_KEY_W   = 9;
  localparam int DEF_BV_W    = 36;
  localparam int DEF_RAM_LAT = 2;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_OUT  = 2'd3
  } state_e;

  function automatic int set_data_w(input int key_w, input int bv_w);
    return key_w + bv_w;
  endfunction

endpackage

// File: rtl/bv_ram_dp.sv
// bv_ram_dp
// True dual-port inferred RAM. Each port has its own read and write enable.
// A read issued in cycle t appears on q_*_o in cycle t+LAT: the array read
// register is the first of LAT output stages.
//   clk                 - clock
//   rden_a_i / wren_a_i - port A read / write enable
//   addr_a_i, wdata_a_i - port A address / write data
//   q_a_o               - port A read data
//   rden_b_i ... q_b_o  - port B, same as port A
// If both ports write the same address in one cycle, port B wins.
module bv_ram_dp #(
  parameter int AW  = 9,
  parameter int DW  = 36,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rden_a_i,
  input  logic          wren_a_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [DW-1:0] wdata_a_i,
  output logic [DW-1:0] q_a_o,
  input  logic          rden_b_i,
  input  logic          wren_b_i,
  input  logic [AW-1:0] addr_b_i,
  input  logic [DW-1:0] wdata_b_i,
  output logic [DW-1:0] q_b_o
);

  logic [DW-1:0] mem    [2**AW];
  logic [DW-1:0] pipe_a [LAT];
  logic [DW-1:0] pipe_b [LAT];

  // Reads return the contents from before a same-cycle write (read-old).
  always_ff @(posedge clk) begin
    if (wren_a_i) mem[addr_a_i] <= wdata_a_i;
    if (wren_b_i) mem[addr_b_i] <= wdata_b_i;
    if (rden_a_i) pipe_a[0] <= mem[addr_a_i];
    if (rden_b_i) pipe_b[0] <= mem[addr_b_i];
    for (int i = 1; i < LAT; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end

  assign q_a_o = pipe_a[LAT-1];
  assign q_b_o = pipe_b[LAT-1];

endmodule

// File: rtl/bv_lookup_stage.sv
// bv_lookup_stage
// Bit-vector lookup stage. The key reads a 2^KEY_W x BV_W rule-vector table
// on RAM port A. Port B serves the init sweep and control-plane set/readback.
// Optional macro BV_LOOKUP_PARITY_EN: stores even parity per entry and adds
// the bv_err output.
//   clk, reset         - clock, async active-low reset
//   set_valid/set_data - table write {addr, vector}, taken when cfg_ready
//   read_valid/addr    - readback request, taken when cfg_ready
//   cfg_ready          - control port idle
//   data_out_valid/out - readback result pulse / held data
//   key_valid/key      - lookup request, no backpressure
//   bv_valid/bv        - lookup result RAM_LAT cycles after key_valid
//   bv_err             - parity mismatch on the result (parity build only)
//   stage_enable       - key_valid delayed one cycle
//
// state      | meaning
// ST_INIT    | zero-fill sweep over the whole table, cfg_ready=0
// ST_IDLE    | accept set (priority) or readback
// ST_RD_WAIT | wait for the port-B read pipeline
// ST_RD_OUT  | readback data presented for one cycle
module bv_lookup_stage
  import bv_lookup_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int BV_W    = DEF_BV_W,
  parameter int RAM_LAT = DEF_RAM_LAT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               set_valid,
  input  logic [set_data_w(KEY_W,BV_W)-1:0]  set_data,
  input  logic                               read_valid,
  input  logic [KEY_W-1:0]                   read_addr,
  output logic                               cfg_ready,
  output logic                               data_out_valid,
  output logic [BV_W-1:0]                    data_out,
  input  logic                               key_valid,
  input  logic [KEY_W-1:0]                   key,
  output logic                               bv_valid,
  output logic [BV_W-1:0]                    bv,
`ifdef BV_LOOKUP_PARITY_EN
  output logic                               bv_err,
`endif
  output logic                               stage_enable
);

`ifdef BV_LOOKUP_PARITY_EN
  localparam int DW = BV_W + 1;
`else
  localparam int DW = BV_W;
`endif

  state_e           state_q, state_d;
  logic [KEY_W-1:0] init_addr_q, init_addr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [BV_W-1:0]  data_out_q, data_out_d;
  logic             dout_vld_q, dout_vld_d;

  logic [KEY_W-1:0] set_addr;
  logic [BV_W-1:0]  set_vec;
  logic [DW-1:0]    set_word, zero_word;
  logic             rden_b, wren_b;
  logic [KEY_W-1:0] addr_b;
  logic [DW-1:0]    wdata_b, q_a, q_b, rd_a;
  logic             fwd_hit;

  logic [RAM_LAT-1:0] vld_q, fwd_q;
  logic [DW-1:0]      fwd_data_q [RAM_LAT];
  logic [BV_W-1:0]    bv_hold_q;

  assign set_addr = set_data[KEY_W+BV_W-1:BV_W];
  assign set_vec  = set_data[BV_W-1:0];
`ifdef BV_LOOKUP_PARITY_EN
  assign set_word  = {^set_vec, set_vec};
`else
  assign set_word  = set_vec;
`endif
  assign zero_word = '0;  // parity of zero is zero

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      dout_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      dout_vld_q  <= dout_vld_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    dout_vld_d  = 1'b0;
    rden_b      = 1'b0;
    wren_b      = 1'b0;
    addr_b      = init_addr_q;
    wdata_b     = zero_word;
    cfg_ready   = 1'b0;
    case (state_q)
      ST_INIT: begin
        wren_b = 1'b1;
        if (init_addr_q == {KEY_W{1'b1}}) state_d = ST_IDLE;
        else init_addr_d = init_addr_q + 1'b1;
      end
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (set_valid) begin
          wren_b  = 1'b1;
          addr_b  = set_addr;
          wdata_b = set_word;
        end else if (read_valid) begin
          rden_b  = 1'b1;
          addr_b  = read_addr;
          cnt_d   = 3'(RAM_LAT - 1);
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // q_b is valid in the cycle the counter reaches 0; capture it so
        // data_out and its valid appear together in ST_RD_OUT.
        if (cnt_q == 3'd0) begin
          data_out_d = q_b[BV_W-1:0];
          dout_vld_d = 1'b1;
          state_d    = ST_RD_OUT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RD_OUT: state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  assign data_out_valid = dout_vld_q;
  assign data_out       = data_out_q;

  bv_ram_dp #(
    .AW  (KEY_W),
    .DW  (DW),
    .LAT (RAM_LAT)
  ) u_ram (
    .clk       (clk),
    .rden_a_i  (key_valid),
    .wren_a_i  (1'b0),
    .addr_a_i  (key),
    .wdata_a_i (zero_word),
    .q_a_o     (q_a),
    .rden_b_i  (rden_b),
    .wren_b_i  (wren_b),
    .addr_b_i  (addr_b),
    .wdata_b_i (wdata_b),
    .q_b_o     (q_b)
  );

  // The RAM returns the old word on a same-cycle collision. The new word
  // travels alongside the read and replaces it at the output.
  assign fwd_hit = (state_q == ST_IDLE) && set_valid && key_valid && (set_addr == key);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      fwd_q     <= '0;
      bv_hold_q <= '0;
      for (int i = 0; i < RAM_LAT; i++) fwd_data_q[i] <= '0;
    end else begin
      vld_q[0]      <= key_valid;
      fwd_q[0]      <= fwd_hit;
      fwd_data_q[0] <= set_word;
      for (int i = 1; i < RAM_LAT; i++) begin
        vld_q[i]      <= vld_q[i-1];
        fwd_q[i]      <= fwd_q[i-1];
        fwd_data_q[i] <= fwd_data_q[i-1];
      end
      if (bv_valid) bv_hold_q <= rd_a[BV_W-1:0];
    end
  end

  assign rd_a         = fwd_q[RAM_LAT-1] ? fwd_data_q[RAM_LAT-1] : q_a;
  assign bv_valid     = vld_q[RAM_LAT-1];
  assign bv           = bv_valid ? rd_a[BV_W-1:0] : bv_hold_q;
  assign stage_enable = vld_q[0];
`ifdef BV_LOOKUP_PARITY_EN
  assign bv_err       = bv_valid & (^rd_a);
`endif

endmodule

// File: tb/tb_bv_lookup_stage.sv
module tb_bv_lookup_stage;
  localparam int KEY_W   = 9;
  localparam int BV_W    = 36;
  localparam int RAM_LAT = 2;
  localparam int DEPTH   = 1 << KEY_W;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  set_valid = 1'b0;
  logic [KEY_W+BV_W-1:0] set_data = '0;
  logic                  read_valid = 1'b0;
  logic [KEY_W-1:0]      read_addr = '0;
  logic                  cfg_ready;
  logic                  data_out_valid;
  logic [BV_W-1:0]       data_out;
  logic                  key_valid = 1'b0;
  logic [KEY_W-1:0]      key = '0;
  logic                  bv_valid;
  logic [BV_W-1:0]       bv;
  logic                  bv_err;
  logic                  stage_enable;

  bv_lookup_stage #(.KEY_W(KEY_W), .BV_W(BV_W), .RAM_LAT(RAM_LAT)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .set_valid      (set_valid),
    .set_data       (set_data),
    .read_valid     (read_valid),
    .read_addr      (read_addr),
    .cfg_ready      (cfg_ready),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .key_valid      (key_valid),
    .key            (key),
    .bv_valid       (bv_valid),
    .bv             (bv),
`ifdef BV_LOOKUP_PARITY_EN
    .bv_err         (bv_err),
`endif
    .stage_enable   (stage_enable)
  );
`ifndef BV_LOOKUP_PARITY_EN
  assign bv_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [BV_W-1:0] bv;
    int              due;
    logic            err;
  } exp_t;
  exp_t sb[$];

  logic [BV_W-1:0] model [DEPTH];

  // Lookup scoreboard: every bv_valid pops one expectation and must land on
  // its due cycle; an expectation whose cycle passes without bv_valid fails.
  always @(negedge clk) begin
    exp_t e;
    if (bv_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL bv_unexpected: bv_valid=1 bv=%h at cycle %0d, required no result", bv, cyc);
      end else begin
        e = sb.pop_front();
        if (bv !== e.bv || cyc !== e.due || bv_err !== e.err) begin
          bad++;
          $display("FAIL bv_result: got bv=%h err=%b cycle=%0d, required bv=%h err=%b cycle=%0d",
                   bv, bv_err, cyc, e.bv, e.err, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL bv_missing: no bv_valid at cycle %0d, required bv=%h", cyc, e.bv);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic idle_inputs();
    set_valid = 1'b0;
    read_valid = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic push_key(input logic [KEY_W-1:0] a, input logic err);
    key_valid = 1'b1;
    key = a;
    sb.push_back('{bv: model[a], due: cyc + RAM_LAT, err: err});
  endtask

  task automatic do_set(input logic [KEY_W-1:0] a, input logic [BV_W-1:0] v);
    set_valid = 1'b1;
    set_data = {a, v};
    model[a] = v;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_init(input string nm);
    int  n = 0;
    logic saw_dv = 1'b0;
    while (!cfg_ready && n < 600) begin
      @(negedge clk);
      n++;
      saw_dv |= data_out_valid;
    end
    total++;
    if (n !== DEPTH || saw_dv !== 1'b0) begin
      bad++;
      $display("FAIL %s: cfg_ready after %0d cycles, data_out_valid seen=%b, required %0d cycles and 0",
               nm, n, saw_dv, DEPTH);
    end
    model_clear();
  endtask

  task automatic readback(input logic [KEY_W-1:0] a, input logic [BV_W-1:0] exp, input string nm);
    int t0, n;
    read_valid = 1'b1;
    read_addr = a;
    t0 = cyc;
    @(negedge clk);
    read_valid = 1'b0;
    n = 0;
    while (!data_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (data_out_valid !== 1'b1 || cyc - t0 !== RAM_LAT + 1 || data_out !== exp) begin
      bad++;
      $display("FAIL %s: latency=%0d data=%h valid=%b, required latency=%0d data=%h",
               nm, cyc - t0, data_out, data_out_valid, RAM_LAT + 1, exp);
    end
    @(negedge clk);
    total++;
    if (data_out_valid !== 1'b0 || data_out !== exp) begin
      bad++;
      $display("FAIL %s_hold: valid=%b data=%h, required valid=0 data=%h", nm, data_out_valid, data_out, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cfg_ready, data_out_valid, bv_valid, stage_enable} !== 4'b0 || data_out !== '0 || bv !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b dv=%b bvv=%b se=%b dout=%h bv=%h, required all 0",
               cfg_ready, data_out_valid, bv_valid, stage_enable, data_out, bv);
    end
    reset = 1'b1;
    wait_init("init_length");
    readback(9'h1FF, '0, "rb_1ff_zero");
  endtask

  task automatic test_set_lookup();
    do_set(9'h005, 36'hA_5A5A_5A5A);
    @(negedge clk);
    set_valid = 1'b0;
    push_key(9'h005, 1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_forward();
    do_set(9'h010, 36'h1);
    push_key(9'h010, 1'b0);
    @(negedge clk);
    do_set(9'h011, 36'h22);
    push_key(9'h012, 1'b0);
    @(negedge clk);
    set_valid = 1'b0;
    push_key(9'h020, 1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    do_set(9'h020, 36'hF_FFFF_FFFF);
    @(negedge clk);
    set_valid = 1'b0;
    push_key(9'h020, 1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_readback();
    int t0, n, pulses;
    readback(9'h005, 36'hA_5A5A_5A5A, "rb_005");
    read_valid = 1'b1;
    read_addr = 9'h005;
    t0 = cyc;
    @(negedge clk);
    set_valid = 1'b1;
    set_data = {9'h005, 36'h1_2345_6789};
    read_addr = 9'h010;
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (!data_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cyc - t0 !== RAM_LAT + 1 || data_out !== 36'hA_5A5A_5A5A) begin
      bad++;
      $display("FAIL rb_during_wait: latency=%0d data=%h, required latency=%0d data=%h",
               cyc - t0, data_out, RAM_LAT + 1, 36'hA_5A5A_5A5A);
    end
    @(negedge clk);
    total++;
    if (data_out_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd_wait_ignored: dv=%b rdy=%b, required dv=0 rdy=1", data_out_valid, cfg_ready);
    end
    readback(9'h005, 36'hA_5A5A_5A5A, "rb_005_unchanged");
    do_set(9'h040, 36'h7);
    read_valid = 1'b1;
    read_addr = 9'h005;
    pulses = 0;
    @(negedge clk);
    idle_inputs();
    repeat (6) begin
      @(negedge clk);
      if (data_out_valid) pulses++;
    end
    total++;
    if (pulses !== 0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL set_priority: readback pulses=%0d rdy=%b, required 0 and 1", pulses, cfg_ready);
    end
    readback(9'h040, 36'h7, "rb_040");
  endtask

  task automatic test_back_to_back();
    logic prev;
    for (int i = 1; i <= 8; i++) begin
      do_set(9'(i), {4'(i), 32'($urandom)});
      @(negedge clk);
    end
    set_valid = 1'b0;
    @(negedge clk);
    prev = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (stage_enable !== prev) begin
        bad++;
        $display("FAIL stage_enable_b2b: got %b at key %0d, required %b", stage_enable, i, prev);
      end
      push_key(9'(i), 1'b0);
      prev = 1'b1;
      @(negedge clk);
    end
    key_valid = 1'b0;
    total++;
    if (stage_enable !== 1'b1) begin
      bad++;
      $display("FAIL stage_enable_last: got %b, required 1", stage_enable);
    end
    @(negedge clk);
    total++;
    if (stage_enable !== 1'b0) begin
      bad++;
      $display("FAIL stage_enable_drop: got %b, required 0", stage_enable);
    end
    wait_drain();
    @(negedge clk);
    total++;
    if (bv_valid !== 1'b0 || bv !== model[8]) begin
      bad++;
      $display("FAIL bv_hold: bvv=%b bv=%h, required bvv=0 bv=%h", bv_valid, bv, model[8]);
    end
  endtask

  task automatic test_reset_mid();
    logic saw = 1'b0;
    push_key(9'h005, 1'b0);
    read_valid = 1'b1;
    read_addr = 9'h005;
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    sb.delete();
    #1;
    total++;
    if ({cfg_ready, data_out_valid, bv_valid, stage_enable} !== 4'b0 || data_out !== '0 || bv !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: rdy=%b dv=%b bvv=%b se=%b dout=%h bv=%h, required all 0",
               cfg_ready, data_out_valid, bv_valid, stage_enable, data_out, bv);
    end
    repeat (5) begin
      @(negedge clk);
      saw |= data_out_valid | bv_valid;
    end
    reset = 1'b1;
    repeat (100) begin
      @(negedge clk);
      saw |= data_out_valid;
    end
    total++;
    if (saw !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_pulse: got a pulse after reset, required none");
    end
    reset = 1'b0;
    #1;
    total++;
    if (cfg_ready !== 1'b0 || bv !== '0 || data_out !== '0) begin
      bad++;
      $display("FAIL reset_in_init: rdy=%b bv=%h dout=%h, required 0", cfg_ready, bv, data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_init("init_restart");
    readback(9'h005, '0, "rb_005_cleared");
    push_key(9'h040, 1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    wait_drain();
  endtask

`ifdef BV_LOOKUP_PARITY_EN
  task automatic test_parity();
    do_set(9'h030, 36'h0_0000_0F0F);
    @(negedge clk);
    set_valid = 1'b0;
    push_key(9'h030, 1'b0);
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    u_dut.u_ram.mem[9'h030] = u_dut.u_ram.mem[9'h030] ^ 37'h1;
    model[9'h030] = model[9'h030] ^ 36'h1;
    push_key(9'h030, 1'b1);
    @(negedge clk);
    key_valid = 1'b0;
    wait_drain();
  endtask
`endif

  initial begin
    test_reset();
    test_set_lookup();
    test_forward();
    test_readback();
    test_back_to_back();
`ifdef BV_LOOKUP_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
